// File: rtl/vga_pkg.sv
// Shared VGA types, raster-size helper and the 16-entry 12-bit colour palette.
// Imported by the timing generator and the overlay top.
package vga_pkg;

    typedef logic [9:0] coord_t;

    function automatic int raster_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00F, 12'hF00, 12'hF8C,
        12'h0FF, 12'hF80, 12'hFF0, 12'hFFF,
        12'h111, 12'h222, 12'h333, 12'h444,
        12'h555, 12'h666, 12'h777, 12'h888
    };

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus first pipeline stage of de/hsync/vsync; frame_start is
// decoded combinationally from the counters on the last pixel of a frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       de1_o,
    output logic       hs1_o,
    output logic       vs1_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = raster_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = raster_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    coord_t hcnt_q, hcnt_d;
    coord_t vcnt_q, vcnt_d;
    logic   de1_q, de1_d;
    logic   hs1_q, hs1_d;
    logic   vs1_q, vs1_d;
    logic   h_wrap;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
        de1_d = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs1_d = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        vs1_d = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    end

    // Syncs idle high in reset so the monitor never sees a spurious pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            de1_q  <= de1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
        end
    end

    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign de1_o         = de1_q;
    assign hs1_o         = hs1_q;
    assign vs1_o         = vs1_q;
    assign frame_start_o = h_wrap && (vcnt_q == V_LAST);

endmodule

// File: rtl/vga_char_overlay.sv
// 640x480@60 raster with a single-colour rectangle overlay; outputs 2 cycles after counters.
// VGA_CHAR_SHADOW_EN: latch rectangle/colour at frame_start so updates land on frame boundaries.
module vga_char_overlay
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  char_x_start,
    input  logic [9:0]  char_x_end,
    input  logic [9:0]  char_y_start,
    input  logic [9:0]  char_y_end,
    input  logic [3:0]  char_color,
    input  logic [3:0]  bg_color,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [11:0] vga_rgb,
    output logic        vga_de,
    output logic        frame_start
);

    coord_t     hcnt, vcnt;
    logic       de1, hs1, vs1, fs;
    coord_t     xs_a, xe_a, ys_a, ye_a;
    logic [3:0] col_a;

    vga_timing_gen #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .hcnt_o        (hcnt),
        .vcnt_o        (vcnt),
        .de1_o         (de1),
        .hs1_o         (hs1),
        .vs1_o         (vs1),
        .frame_start_o (fs)
    );

`ifdef VGA_CHAR_SHADOW_EN
    coord_t     xs_q, xe_q, ys_q, ye_q;
    logic [3:0] col_q;

    // Captured on the last pixel so the new values start exactly at pixel (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs_q  <= '0;
            xe_q  <= '0;
            ys_q  <= '0;
            ye_q  <= '0;
            col_q <= '0;
        end else if (fs) begin
            xs_q  <= char_x_start;
            xe_q  <= char_x_end;
            ys_q  <= char_y_start;
            ye_q  <= char_y_end;
            col_q <= char_color;
        end
    end

    assign xs_a  = xs_q;
    assign xe_a  = xe_q;
    assign ys_a  = ys_q;
    assign ye_a  = ye_q;
    assign col_a = col_q;
`else
    assign xs_a  = char_x_start;
    assign xe_a  = char_x_end;
    assign ys_a  = char_y_start;
    assign ye_a  = char_y_end;
    assign col_a = char_color;
`endif

    logic        hit1_q, hit1_d;
    logic [3:0]  col1_q;
    logic [11:0] rgb2_q, rgb2_d;
    logic        de2_q, hs2_q, vs2_q;

    // Inverted bounds (start > end) can never satisfy both compares.
    always_comb begin
        hit1_d = (hcnt >= xs_a) && (hcnt <= xe_a) && (vcnt >= ys_a) && (vcnt <= ye_a);
        rgb2_d = 12'h000;
        if (de1) begin
            if (hit1_q && (col1_q != 4'd0)) begin
                rgb2_d = PALETTE[col1_q];
            end else begin
                rgb2_d = PALETTE[bg_color];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit1_q <= 1'b0;
            col1_q <= '0;
            rgb2_q <= '0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            hit1_q <= hit1_d;
            col1_q <= col_a;
            rgb2_q <= rgb2_d;
            de2_q  <= de1;
            hs2_q  <= hs1;
            vs2_q  <= vs1;
        end
    end

    assign vga_rgb     = rgb2_q;
    assign vga_de      = de2_q;
    assign vga_hsync   = hs2_q;
    assign vga_vsync   = vs2_q;
    assign frame_start = fs;

endmodule

// File: tb/tb_vga_char_overlay.sv
// Directed checks of vga_char_overlay on a small 56x27 raster (visible 40x20).
// Pixel (h,v) of frame f appears at the outputs after edge f*FT + v*HT + h + 2.
module tb_vga_char_overlay;

    localparam int HT = 56;
    localparam int VT = 27;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  char_x_start = '0;
    logic [9:0]  char_x_end   = '0;
    logic [9:0]  char_y_start = '0;
    logic [9:0]  char_y_end   = '0;
    logic [3:0]  char_color   = '0;
    logic [3:0]  bg_color     = '0;
    logic        vga_hsync, vga_vsync, vga_de, frame_start;
    logic [11:0] vga_rgb;

    int n_chk = 0;
    int n_err = 0;
    int cur   = 0;
    bit shadow;

    vga_char_overlay #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .char_x_start (char_x_start),
        .char_x_end   (char_x_end),
        .char_y_start (char_y_start),
        .char_y_end   (char_y_end),
        .char_color   (char_color),
        .bg_color     (bg_color),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .vga_rgb      (vga_rgb),
        .vga_de       (vga_de),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cur);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cur++;
        #2;
    endtask

    task automatic goto_edge(input int k);
        while (cur < k) step();
        if (cur != k) check("sequence", cur, k);
    endtask

    function automatic int kpix(input int f, input int h, input int v);
        return f * FT + v * HT + h + 2;
    endfunction

    task automatic set_rect(input int xs, input int xe, input int ys, input int ye,
                            input int col, input int bg);
        char_x_start = 10'(xs);
        char_x_end   = 10'(xe);
        char_y_start = 10'(ys);
        char_y_end   = 10'(ye);
        char_color   = 4'(col);
        bg_color     = 4'(bg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, vga_hsync, 1'b1);
        check({tag, "_vs"}, vga_vsync, 1'b1);
        check({tag, "_rgb"}, vga_rgb, 12'h000);
        check({tag, "_de"}, vga_de, 1'b0);
        check({tag, "_fs"}, frame_start, 1'b0);
    endtask

    initial begin
`ifdef VGA_CHAR_SHADOW_EN
        shadow = 1'b1;
`else
        shadow = 1'b0;
`endif
        set_rect(10, 13, 5, 7, 6, 0);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        rst = 1'b0;
        cur = 0;

        // Frame 0: latency and sync timing
        goto_edge(1);
        check("lat_de_e1", vga_de, 1'b0);
        goto_edge(2);
        check("lat_de_e2", vga_de, 1'b1);
        goto_edge(kpix(0, 39, 0)); check("de_h39", vga_de, 1'b1);
        goto_edge(kpix(0, 40, 0)); check("de_h40", vga_de, 1'b0);
        goto_edge(kpix(0, 43, 0)); check("hs_h43", vga_hsync, 1'b1);
        goto_edge(kpix(0, 44, 0)); check("hs_h44", vga_hsync, 1'b0);
        goto_edge(kpix(0, 49, 0)); check("hs_h49", vga_hsync, 1'b0);
        goto_edge(kpix(0, 50, 0)); check("hs_h50", vga_hsync, 1'b1);
        goto_edge(kpix(0, 0, 19)); check("de_v19", vga_de, 1'b1);
        goto_edge(kpix(0, 0, 20)); check("de_v20", vga_de, 1'b0);
        goto_edge(kpix(0, 0, 21)); check("vs_v21", vga_vsync, 1'b1);
        goto_edge(kpix(0, 0, 22)); check("vs_v22", vga_vsync, 1'b0);
        goto_edge(kpix(0, 55, 23)); check("vs_v23", vga_vsync, 1'b0);
        goto_edge(kpix(0, 0, 24)); check("vs_v24", vga_vsync, 1'b1);
        goto_edge(FT - 2); check("fs_before", frame_start, 1'b0);
        goto_edge(FT - 1); check("fs_last", frame_start, 1'b1);
        goto_edge(FT);     check("fs_after", frame_start, 1'b0);

        // Frame 1: rectangle x=10..13 y=5..7 colour 6 (FF0) on black
        goto_edge(kpix(1, 10, 4)); check("rect_above", vga_rgb, 12'h000);
        goto_edge(kpix(1, 9, 5));  check("rect_left", vga_rgb, 12'h000);
        goto_edge(kpix(1, 10, 5)); check("rect_tl", vga_rgb, 12'hFF0);
        goto_edge(kpix(1, 13, 7)); check("rect_br", vga_rgb, 12'hFF0);
        goto_edge(kpix(1, 14, 7)); check("rect_right", vga_rgb, 12'h000);
        goto_edge(kpix(1, 12, 8)); check("rect_below", vga_rgb, 12'h000);
        set_rect(30, 29, 5, 7, 6, 2);

        // Frame 2: inverted x range shows only background F00
        goto_edge(kpix(2, 29, 6)); check("degen_29", vga_rgb, 12'hF00);
        goto_edge(kpix(2, 30, 6)); check("degen_30", vga_rgb, 12'hF00);
        goto_edge(kpix(2, 50, 6)); check("blank_rgb", vga_rgb, 12'h000);
        check("blank_de", vga_de, 1'b0);
        set_rect(0, 39, 0, 19, 0, 1);

        // Frame 3: transparent character, background 00F
        goto_edge(kpix(3, 0, 0));   check("transp_00", vga_rgb, 12'h00F);
        goto_edge(kpix(3, 20, 10)); check("transp_mid", vga_rgb, 12'h00F);
        goto_edge(kpix(3, 40, 10)); check("transp_blank", vga_rgb, 12'h000);
        goto_edge(kpix(3, 39, 19)); check("transp_end", vga_rgb, 12'h00F);
        set_rect(10, 13, 0, 19, 7, 0);

        // Frame 4: move the rectangle mid-frame
        goto_edge(kpix(4, 11, 5)); check("mv_pre", vga_rgb, 12'hFFF);
        goto_edge(kpix(4, 0, 10));
        char_x_start = 10'd20;
        char_x_end   = 10'd23;
        goto_edge(kpix(4, 11, 12)); check("mv_old_pos", vga_rgb, shadow ? 12'hFFF : 12'h000);
        goto_edge(kpix(4, 21, 12)); check("mv_new_pos", vga_rgb, shadow ? 12'h000 : 12'hFFF);
        goto_edge(kpix(5, 11, 3));  check("mv_f5_old", vga_rgb, 12'h000);
        goto_edge(kpix(5, 21, 3));  check("mv_f5_new", vga_rgb, 12'hFFF);

        // Asynchronous reset mid-frame
        goto_edge(kpix(5, 21, 15)); check("prerst_rgb", vga_rgb, 12'hFFF);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        cur = 0;
        goto_edge(1);  check("rel_de_e1", vga_de, 1'b0);
        goto_edge(2);  check("rel_de_e2", vga_de, 1'b1);
        check("rel_rgb_00", vga_rgb, 12'h000);
        goto_edge(kpix(0, 44, 0)); check("rel_hs44", vga_hsync, 1'b0);
        goto_edge(FT - 2); check("rel_fs_before", frame_start, 1'b0);
        goto_edge(FT - 1); check("rel_fs_first", frame_start, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
